lsu_ctrl: RTL and testbench

Load/store unit sitting between the core's memory-stage request and the word-wide data memory (256×32, combinational read, write on rising edge). Converts byte/halfword/word loads and stores into word accesses: lane extraction with sign/zero extension for loads, read-modify-write for sub-word stores. Misaligned-access detection is optional. Single request/response handshake; one transaction in flight.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_align.sv | 50 +++++
 rtl/lsu_ctrl.sv | 151 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, and lane helpers.
// Misalignment checks are only used when LSU_MISALIGN_TRAP_EN is defined.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_X = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STORE,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_RESP
  } state_e;

  // Byte lanes touched by an access; word (and illegal, when not trapped) covers all four.
  function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] off);
    case (size)
      SZ_B:    lane_mask = 4'b0001 << off;
      SZ_H:    lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input size_e size, input logic [1:0] off);
    case (size)
      SZ_X:    misaligned = 1'b1;
      SZ_H:    misaligned = off[0];
      SZ_W:    misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: extract/extend a load lane, merge store data into a read word.
// Offending low address bits are ignored here; fault policy lives in lsu_ctrl.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rd_word_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [3:0]  mask;
  logic [31:0] wrep;

  assign ld_byte = rd_word_i[{off_i, 3'b000} +: 8];
  assign ld_half = rd_word_i[{off_i[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: default assigned first so no path leaves the output unassigned (no latch).
    ld_data_o = rd_word_i;
    case (size_e'(size_i))
      SZ_B:    ld_data_o = {{24{sign_i & ld_byte[7]}}, ld_byte};
      SZ_H:    ld_data_o = {{16{sign_i & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

  // Replicate the right-aligned store value so every candidate lane carries it.
  always_comb begin
    wrep = wdata_i;
    case (size_e'(size_i))
      SZ_B:    wrep = {4{wdata_i[7:0]}};
      SZ_H:    wrep = {2{wdata_i[15:0]}};
      default: ;
    endcase
  end

  assign mask = lane_mask(size_e'(size_i), off_i);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign st_word_o[8*i +: 8] = mask[i] ? wrep[8*i +: 8] : old_word_i[8*i +: 8];
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit FSM: one request in flight, word memory port, RMW for sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to report misaligned/illegal accesses via rsp_err.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_A,
  output logic [31:0]       mem_WD,
  output logic              mem_WE,
  input  logic [31:0]       mem_RD
);

  state_e            state_q;
  logic              ready_q;
  logic              rsp_valid_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic [ADDR_W-1:2] addr_q;
  logic [1:0]        off_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rd_word_q;

  logic              fault;
  logic [31:0]       ld_data;
  logic [31:0]       st_word;

`ifdef LSU_MISALIGN_TRAP_EN
  assign fault = misaligned(size_e'(req_size), req_addr[1:0]);
`else
  assign fault = 1'b0;
`endif

  lsu_align u_align (
    .size_i     (size_q),
    .sign_i     (sign_q),
    .off_i      (off_q),
    .rd_word_i  (mem_RD),
    .old_word_i (rd_word_q),
    .wdata_i    (wdata_q),
    .ld_data_o  (ld_data),
    .st_word_o  (st_word)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      size_q      <= SZ_B;
      sign_q      <= 1'b0;
      addr_q      <= '0;
      off_q       <= '0;
      wdata_q     <= '0;
      rd_word_q   <= '0;
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            size_q  <= req_size;
            sign_q  <= req_sign;
            addr_q  <= req_addr[ADDR_W-1:2];
            off_q   <= req_addr[1:0];
            wdata_q <= req_wdata;
            rdata_q <= '0;
            err_q   <= fault;
            ready_q <= 1'b0;
            if (fault) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
            end else if (!req_we) begin
              state_q <= ST_LOAD;
            end else if (req_size[1]) begin
              // Size 3 only gets here when untrapped, and is then a word store.
              state_q <= ST_STORE;
            end else begin
              state_q <= ST_RMW_RD;
            end
          end
        end
        ST_LOAD: begin
          rdata_q     <= ld_data;
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
        end
        ST_STORE: begin
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
        end
        ST_RMW_RD: begin
          rd_word_q <= mem_RD;
          state_q   <= ST_RMW_WR;
        end
        ST_RMW_WR: begin
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign mem_A = (state_q == ST_IDLE) ? '0 : {addr_q, 2'b00};

  // Gated by RST directly so an RMW aborted in its write cycle never reaches memory.
  assign mem_WE = ((state_q == ST_STORE) || (state_q == ST_RMW_WR)) && !RST;

  always_comb begin
    mem_WD = '0;
    case (state_q)
      ST_STORE:  mem_WD = wdata_q;
      ST_RMW_WR: mem_WD = st_word;
      default:   ;
    endcase
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: word memory model, reference memory and
// per-cycle compare against expected responses derived from access rules.
module tb_lsu_ctrl;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_sign = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  always #5 CLK = ~CLK;

  lsu_ctrl #(.ADDR_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  assign mem_RD = mem[mem_A[9:2]];
  always @(posedge CLK) if (mem_WE) mem[mem_A[9:2]] <= mem_WD;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model of the transaction in flight.
  bit          chk_en = 1'b0;
  bit          have_exp = 1'b0;
  int          exp_cyc;
  logic [31:0] exp_rdata;
  logic        exp_err;
  logic [31:0] exp_maddr;
  int          exp_wes;
  bit          pend_wr;
  int          pend_idx;
  logic [31:0] pend_word;
  int          we_cnt = 0;
  int          we_base = 0;
  int          last_rsp_cyc = 0;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic model_accept(input logic we, input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, input logic [31:0] wd, input int acc);
    logic [31:0] w, v, m;
    logic [1:0]  esz;
    bit          flt;
    int          sh, lat;
    flt = TRAP && (sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00));
    esz = (sz == 2'd3) ? 2'd2 : sz;
    w = ref_mem[a[9:2]];
    sh = (esz == 2'd0) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
    exp_maddr = {a[31:2], 2'b00};
    exp_err   = flt;
    exp_rdata = '0;
    exp_wes   = 0;
    pend_wr   = 1'b0;
    we_base   = we_cnt;
    if (flt) begin
      lat = 1;
    end else if (!we) begin
      lat = 2;
      if (esz == 2'd0) begin
        v = (w >> sh) & 32'hFF;
        if (sg && v[7]) v = v | 32'hFFFF_FF00;
      end else if (esz == 2'd1) begin
        v = (w >> sh) & 32'hFFFF;
        if (sg && v[15]) v = v | 32'hFFFF_0000;
      end else begin
        v = w;
      end
      exp_rdata = v;
    end else begin
      pend_wr  = 1'b1;
      exp_wes  = 1;
      pend_idx = int'(a[9:2]);
      if (esz == 2'd2) begin
        lat = 2;
        pend_word = wd;
      end else begin
        lat = 3;
        m = ((esz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
        pend_word = (w & ~m) | ((wd << sh) & m);
      end
    end
    exp_cyc  = acc + lat;
    have_exp = 1'b1;
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      if (mem_WE) we_cnt++;
      check("req_ready", {31'b0, req_ready}, {31'b0, !have_exp});
      check("mem_A", mem_A, have_exp ? exp_maddr : 32'h0);
      if (!have_exp) check("mem_WE_idle", {31'b0, mem_WE}, 32'h0);
      if (have_exp && cyc == exp_cyc) begin
        check("rsp_valid", {31'b0, rsp_valid}, 32'h1);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
        check("we_pulses", we_cnt - we_base, exp_wes);
        if (pend_wr) ref_mem[pend_idx] = pend_word;
        last_rsp_cyc = cyc;
        last_rdata   = rsp_rdata;
        last_err     = rsp_err;
        have_exp     = 1'b0;
      end else begin
        check("rsp_valid_low", {31'b0, rsp_valid}, 32'h0);
      end
    end
  end

  // Returns acc = index of the accept cycle (the IDLE cycle whose closing edge takes the request).
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, output int acc);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = sz;
    req_sign  = sg;
    req_addr  = a;
    req_wdata = wd;
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (req_ready) begin
        @(posedge CLK);
        #1;
        acc = cyc - 1;
        break;
      end
    end
    req_valid = 1'b0;
    if (acc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got no acceptance, expected within 20 cycles");
    end else begin
      model_accept(we, sz, sg, a, wd, acc);
    end
  endtask

  task automatic wait_rsp();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      #1;
      if (!have_exp) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: got no response, expected one by cycle %0d", exp_cyc);
      have_exp = 1'b0;
    end
  endtask

  // Abort the transaction in flight after 'extra' more cycles by pulsing RST for one cycle.
  task automatic abort_after(input int extra);
    repeat (extra) begin
      @(posedge CLK);
      #1;
    end
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    have_exp = 1'b0;
    pend_wr  = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int acc, acc2, ndiff;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = (32'(i) * 32'h0101_0101) ^ 32'h3C3C_0000;
      ref_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'h3C3C_0000;
    end
    mem[32'h80 >> 2]     = 32'h8899_AABB;
    ref_mem[32'h80 >> 2] = 32'h8899_AABB;

    // Reset state
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_ready", {31'b0, req_ready}, 32'h1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
    check("rst_mem_WE", {31'b0, mem_WE}, 32'h0);
    check("rst_mem_A", mem_A, 32'h0);
    check("rst_mem_WD", mem_WD, 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    chk_en = 1'b1;

    // Byte loads from 0x8899AABB @0x81
    do_req(1'b0, 2'd0, 1'b1, 32'h81, 32'h0, acc);
    wait_rsp();
    check("lb_signed", last_rdata, 32'hFFFF_FFAA);
    check("lb_latency", last_rsp_cyc - acc, 32'd2);
    do_req(1'b0, 2'd0, 1'b0, 32'h81, 32'h0, acc);
    wait_rsp();
    check("lbu", last_rdata, 32'h0000_00AA);

    // Half store @0x82 via read-modify-write
    do_req(1'b1, 2'd1, 1'b0, 32'h82, 32'h0000_1234, acc);
    wait_rsp();
    check("sh_latency", last_rsp_cyc - acc, 32'd3);
    check("sh_mem", mem[32'h80 >> 2], 32'h1234_AABB);
    check("sh_we_count", we_cnt - we_base, 32'd1);

    do_req(1'b0, 2'd1, 1'b1, 32'h80, 32'h0, acc);
    wait_rsp();
    check("lh_signed_neg", last_rdata, 32'hFFFF_AABB);
    do_req(1'b0, 2'd1, 1'b1, 32'h82, 32'h0, acc);
    wait_rsp();
    check("lh_signed_pos", last_rdata, 32'h0000_1234);

    // Word store then back-to-back word load
    do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEAD_BEEF, acc);
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, acc2);
    check("b2b_accept", acc2, last_rsp_cyc + 1);
    check("sw_latency", last_rsp_cyc - acc, 32'd2);
    wait_rsp();
    check("lw", last_rdata, 32'hDEAD_BEEF);

    // Byte store into a pattern word, unsigned byte reload
    do_req(1'b1, 2'd0, 1'b0, 32'h45, 32'hFFFF_FF5A, acc);
    wait_rsp();
    do_req(1'b0, 2'd0, 1'b0, 32'h45, 32'h0, acc);
    wait_rsp();
    check("lbu_after_sb", last_rdata, 32'h0000_005A);

    // Misaligned / illegal accesses
    do_req(1'b0, 2'd2, 1'b0, 32'h42, 32'h0, acc);
    wait_rsp();
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw_mis_err", {31'b0, last_err}, 32'h1);
    check("lw_mis_rdata", last_rdata, 32'h0);
    check("lw_mis_latency", last_rsp_cyc - acc, 32'd1);
`else
    check("lw_mis_err", {31'b0, last_err}, 32'h0);
    check("lw_mis_rdata", last_rdata, 32'hDEAD_BEEF);
`endif
    do_req(1'b1, 2'd1, 1'b0, 32'h43, 32'h0000_CAFE, acc);
    wait_rsp();
`ifdef LSU_MISALIGN_TRAP_EN
    check("sh_mis_err", {31'b0, last_err}, 32'h1);
    check("sh_mis_mem", mem[32'h40 >> 2], 32'hDEAD_BEEF);
    check("sh_mis_we", we_cnt - we_base, 32'd0);
`else
    check("sh_mis_mem", mem[32'h40 >> 2], 32'hCAFE_BEEF);
`endif
    do_req(1'b0, 2'd3, 1'b1, 32'h80, 32'h0, acc);
    wait_rsp();
`ifdef LSU_MISALIGN_TRAP_EN
    check("ld_sz3_err", {31'b0, last_err}, 32'h1);
`else
    check("ld_sz3_word", last_rdata, 32'h1234_AABB);
`endif

    // Reset during RMW_RD of a byte store
    do_req(1'b1, 2'd0, 1'b0, 32'h85, 32'h77, acc);
    abort_after(0);
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    check("abort_rd_mem", mem[32'h84 >> 2], ref_mem[32'h84 >> 2]);
    check("abort_rd_we", we_cnt - we_base, 32'd0);

    // Reset during RMW_WR: write enable must be suppressed in that cycle
    do_req(1'b1, 2'd0, 1'b0, 32'h83, 32'h66, acc);
    abort_after(1);
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    check("abort_wr_mem", mem[32'h80 >> 2], 32'h1234_AABB);
    check("abort_wr_we", we_cnt - we_base, 32'd0);

    do_req(1'b0, 2'd0, 1'b0, 32'h83, 32'h0, acc);
    wait_rsp();
    check("recover_lbu", last_rdata, 32'h0000_0012);

    ndiff = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) ndiff++;
    check("mem_image_diffs", ndiff, 32'd0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
